// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter FSM states and the
// clocks-per-bit calculation used by the transmitter (and later the receiver).
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_CNT_MAX-1 while run is high and strobes
// bit_end in the last clock of every bit. clear restarts the period at a frame start.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int BAUD_CNT_MAX = 434
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            run,
    output logic [$clog2(BAUD_CNT_MAX)-1:0] cnt,
    output logic                            bit_end
);

    localparam int              CNT_W = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_CNT_MAX - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign bit_end = run && (cnt_reg == LAST);
    assign cnt     = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= bit_end ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one DATA_W-bit word per valid/ready handshake, framed as
// start, LSB-first data, optional parity (UART_TX_PARITY_EN) and STOP_BITS stop bits.
`timescale 1ns/1ps
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]        parity_mode,
`endif
    output logic              uart_txd,
    output logic              uart_tx_busy,
    output logic              tx_done
);

    localparam int               BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int               CNT_W        = $clog2(BAUD_CNT_MAX);
    localparam logic [3:0]       LAST_DATA    = 4'(DATA_W - 1);
    localparam logic [3:0]       LAST_STOP    = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(BAUD_CNT_MAX - 2);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 2) begin : g_bad_baud
        $error("uart_tx_frame: CLK_FREQ/UART_BPS must be at least 2");
    end

    tx_state_t         state_reg, state_next;
    logic              txd_reg, txd_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [3:0]        idx_reg, idx_next;
`ifdef UART_TX_PARITY_EN
    logic              par_en_reg, par_en_next;
    logic              par_bit_reg, par_bit_next;
`endif

    logic [CNT_W-1:0]  cnt;
    logic              bit_end;
    logic              accept;
    logic              last_stop;

    uart_baud_gen #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .run    (state_reg != ST_IDLE),
        .cnt    (cnt),
        .bit_end(bit_end)
    );

    // Ready in IDLE and in the very last clock of the final stop bit so frames chain gaplessly.
    assign last_stop    = (idx_reg == LAST_STOP);
    assign tx_ready     = (state_reg == ST_IDLE) || ((state_reg == ST_STOP) && last_stop && bit_end);
    assign accept       = tx_valid && tx_ready;
    assign uart_txd     = txd_reg;
    assign uart_tx_busy = busy_reg;
    assign tx_done      = done_reg;

    always_comb begin
        state_next = state_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        // Registered one clock early so tx_done lines up with the last stop clock.
        done_next  = (state_reg == ST_STOP) && last_stop && (cnt == PRE_LAST_CNT);
`ifdef UART_TX_PARITY_EN
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                txd_next = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    txd_next   = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    idx_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_reg == LAST_DATA) begin
                        state_next = ST_STOP;
                        txd_next   = 1'b1;
                        idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_reg) begin
                            state_next = ST_PARITY;
                            txd_next   = par_bit_reg;
                        end
`endif
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        txd_next   = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    txd_next   = 1'b1;
                    idx_next   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        if (accept) begin
            state_next = ST_START;
            txd_next   = 1'b0;
            busy_next  = 1'b1;
            shift_next = tx_data;
            idx_next   = '0;
`ifdef UART_TX_PARITY_EN
            par_en_next  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit_next = (parity_mode == PAR_ODD) ? ~(^tx_data) : (^tx_data);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            shift_reg <= '0;
            idx_reg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
`ifdef UART_TX_PARITY_EN
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at 10 clocks per bit: 8N1 (plus 8E1/8O1 when
// UART_TX_PARITY_EN is defined), 7N2, back-to-back, mid-frame valid and reset.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a = 8'h00;
    logic       tx_ready_a, txd_a, busy_a, done_a;
`ifdef UART_TX_PARITY_EN
    logic [1:0] mode_a = 2'b00;
`endif

    logic       tx_valid_b = 1'b0;
    logic [6:0] tx_data_b = 7'h00;
    logic       tx_ready_b, txd_b, busy_b, done_b;
`ifdef UART_TX_PARITY_EN
    logic [1:0] mode_b = 2'b00;
`endif

    logic       sel_b = 1'b0;
    logic       txd_s, busy_s, done_s, ready_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .CLK_FREQ (1000000),
        .UART_BPS (100000),
        .DATA_W   (8),
        .STOP_BITS(1)
    ) u_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid_a),
        .tx_data     (tx_data_a),
        .tx_ready    (tx_ready_a),
`ifdef UART_TX_PARITY_EN
        .parity_mode (mode_a),
`endif
        .uart_txd    (txd_a),
        .uart_tx_busy(busy_a),
        .tx_done     (done_a)
    );

    uart_tx_frame #(
        .CLK_FREQ (1000000),
        .UART_BPS (100000),
        .DATA_W   (7),
        .STOP_BITS(2)
    ) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid_b),
        .tx_data     (tx_data_b),
        .tx_ready    (tx_ready_b),
`ifdef UART_TX_PARITY_EN
        .parity_mode (mode_b),
`endif
        .uart_txd    (txd_b),
        .uart_tx_busy(busy_b),
        .tx_done     (done_b)
    );

    always_comb begin
        txd_s   = sel_b ? txd_b      : txd_a;
        busy_s  = sel_b ? busy_b     : busy_a;
        done_s  = sel_b ? done_b     : done_a;
        ready_s = sel_b ? tx_ready_b : tx_ready_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Samples every clock from A+1 for nbits bit periods; bits[] is the line level per bit.
    task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits);
        int ones;
        int done_cnt = 0;
        int done_at = 0;
        int busy_cnt = 0;
        int ready_at_done = 0;
        for (int b = 0; b < nbits; b++) begin
            ones = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                ones     += int'(txd_s);
                busy_cnt += int'(busy_s);
                if (done_s) begin
                    done_cnt++;
                    done_at       = b * 10 + k + 1;
                    ready_at_done = int'(ready_s);
                end
            end
            check($sformatf("%s_bit%0d_high_clocks", tag, b), ones, bits[b] ? 10 : 0);
        end
        check($sformatf("%s_done_count", tag), done_cnt, 1);
        check($sformatf("%s_done_clock", tag), done_at, nbits * 10);
        check($sformatf("%s_ready_at_done", tag), ready_at_done, 1);
        check($sformatf("%s_busy_clocks", tag), busy_cnt, nbits * 10);
        $display("frame %s: %0d bits, done at clock %0d", tag, nbits, done_at);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_txd"}, txd_s, 1);
        check({tag, "_idle_busy"}, busy_s, 0);
        check({tag, "_idle_ready"}, ready_s, 1);
    endtask

    task automatic start_a(input string tag, input logic [7:0] d);
        @(negedge clk);
        tx_valid_a = 1'b1;
        tx_data_a  = d;
        check({tag, "_ready_before_accept"}, tx_ready_a, 1);
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_data_a  = ~d;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_txd", txd_a, 1);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_ready", tx_ready_a, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0x55: start 0, data 1,0,1,0,1,0,1,0, stop 1
        start_a("f55", 8'h55);
        run_frame("f55", 16'b0000_0010_1010_1010, 10);
        check_idle("f55");

`ifdef UART_TX_PARITY_EN
        // 0xA7 has five ones: even parity bit 1, odd parity bit 0
        mode_a = 2'b01;
        start_a("e_a7", 8'hA7);
        mode_a = 2'b10;
        run_frame("e_a7", 16'b0000_0111_0100_1110, 11);
        check_idle("e_a7");
        mode_a = 2'b10;
        start_a("o_a7", 8'hA7);
        mode_a = 2'b01;
        run_frame("o_a7", 16'b0000_0101_0100_1110, 11);
        check_idle("o_a7");
        mode_a = 2'b00;
`endif

        // 7N2 0x7F: start 0, seven 1s, two stop 1s -> last 20 clocks high too
        sel_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b1;
        tx_data_b  = 7'h7F;
        check("f7f_ready_before_accept", tx_ready_b, 1);
        @(posedge clk);
        #1;
        tx_valid_b = 1'b0;
        tx_data_b  = 7'h00;
        run_frame("f7f", 16'b0000_0011_1111_1110, 10);
        check_idle("f7f");
        sel_b = 1'b0;

        // Back-to-back: 0x31, 0xC4, 0x0F with tx_valid held high
        @(negedge clk);
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h31;
        @(posedge clk);
        #1;
        tx_data_a = 8'hC4;
        run_frame("b2b_31", 16'b0000_0010_0110_0010, 10);
        @(posedge clk);
        #1;
        tx_data_a = 8'h0F;
        run_frame("b2b_c4", 16'b0000_0011_1000_1000, 10);
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hFF;
        run_frame("b2b_0f", 16'b0000_0010_0001_1110, 10);
        check_idle("b2b");

        // Valid raised mid-frame is held off until the last stop clock
        start_a("f3c", 8'h3C);
        fork
            run_frame("f3c", 16'b0000_0010_0111_1000, 10);
            begin
                repeat (30) @(negedge clk);
                tx_valid_a = 1'b1;
                tx_data_a  = 8'h81;
                check("midframe_ready_low", tx_ready_a, 0);
            end
        join
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'h00;
        run_frame("f81", 16'b0000_0011_0000_0010, 10);
        check_idle("f81");

        // Reset at clock 35 of a frame of zeros, then a clean frame
        start_a("rst00", 8'h00);
        repeat (35) @(negedge clk);
        check("rst_pre_txd_low", txd_a, 0);
        rst_n = 1'b0;
        #1;
        check("rst_txd", txd_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ready", tx_ready_a, 1);
        $display("reset applied mid-frame");
        @(negedge clk);
        rst_n = 1'b1;
        start_a("post_rst", 8'h55);
        run_frame("post_rst", 16'b0000_0010_1010_1010, 10);
        check_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one DATA_W-bit word per valid/ready handshake into an asynchronous frame: start bit, LSB-first data, optional parity, and one or two full-length stop bits. It sits between on-chip producers (command/response logic, FIFOs) and the board TX pin. Successive frames can be sent back-to-back with no idle gap.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS clocks per bit (integer division)
- DATA_W, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  producer has a word
- tx_data  in  DATA_W  word to send, sampled on accept
- tx_ready  out  1  block can accept a word this cycle
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled on accept (present only with UART_TX_PARITY_EN)
- uart_txd  out  1  serial line, idle high
- uart_tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at the end of each frame

## Operation
- Reset values: uart_txd=1, uart_tx_busy=0, tx_done=0, tx_ready=1, state IDLE, all counters 0.
- Accept = tx_valid && tx_ready. On accept, latch tx_data and parity_mode; later input changes have no effect on the frame.
- tx_ready is high in IDLE and in the last clock of the final stop bit; otherwise low. While tx_ready is low, tx_valid is ignored, and no word is dropped or queued.
- FSM: IDLE -> START (on accept) -> DATA (DATA_W bits, LSB first) -> PARITY (only if the latched mode is even or odd) -> STOP (STOP_BITS bits) -> IDLE, or -> START if an accept occurs in the last STOP clock.
- Each state or bit lasts exactly BAUD_CNT_MAX clocks, counted by a bit counter that resets at every bit boundary. Stop bits are full length, never truncated.
- Parity bit: even = XOR of the data bits; odd = inverse of that XOR.
- Frame length = (1 + DATA_W + P + STOP_BITS) x BAUD_CNT_MAX clocks, with P = 1 if parity is enabled, else 0.
- Reset asserted mid-frame: uart_txd goes high asynchronously and the FSM returns to IDLE. The partial frame is abandoned.
- Elaboration error if DATA_W is outside 5..9, STOP_BITS is not 1 or 2, or BAUD_CNT_MAX < 2.

## Timing
- All outputs are registered except tx_ready, which is decoded combinationally from state and counters.
- uart_txd falls 1 clock after the accept edge. The start bit is therefore visible from cycle A+1 through A+BAUD_CNT_MAX, where A is the accept cycle.
- uart_tx_busy rises with the start bit and falls the cycle after the last stop clock. If a back-to-back accept occurs, it stays high.
- tx_done is high during the last clock of the final stop bit, coincident with that clock's tx_ready.
- Back-to-back frames: the stop bit is followed directly by the next start bit, with zero idle clocks.
- Baud counter width is $clog2(BAUD_CNT_MAX). The bit index counter is 4 bits.

## Configuration
- UART_TX_PARITY_EN defined: the parity_mode port and the PARITY state exist.
- UART_TX_PARITY_EN undefined: the parity_mode port is absent, P = 0 always, and the PARITY state logic is not generated.

## Structure
- Package uart_pkg holds:
  - the parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - the FSM state typedef
  - the BAUD_CNT_MAX computation function
- Sub-module uart_baud_gen: a bit-period counter with a clear-on-start input and a bit_end strobe in the last clock of each bit. The same sub-module is to be shared with the future receiver.

## Test plan
Use CLK_FREQ=1000000 and UART_BPS=100000, giving 10 clocks per bit.
- 8N1, send 0x55: line low for 10 clocks, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then high for 10 clocks; frame is 100 clocks; tx_done pulses at clock 100.
- 8E1 sending 0xA7 gives parity bit 1; 8O1 sending 0xA7 gives parity bit 0. Frame is 110 clocks.
- STOP_BITS=2, DATA_W=7, send 0x7F: 10 bits total = 100 clocks; the final 20 clocks are high.
- tx_valid held high with 3 words: start bits begin exactly 100 clocks apart, with no idle clock between frames; each accept coincides with tx_done.
- Assert tx_valid mid-frame, then change tx_data after accept: the word is not accepted until tx_ready, and the transmitted frame uses the latched data.
- rst_n low at clock 35 of a frame: uart_txd=1 immediately, busy=0, tx_ready=1; the next frame is sent correctly.
